// File: rtl/proc_pkg.sv
// ============================================================================
// Module      : proc_pkg
// Description : Opcodes and controller state encoding shared by fetch,
//               execute and trace logic of the single-core processor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_JUMP = 5'b10001;

    // Encoding is fixed so execute/trace can decode a captured state value.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the PC, fetches from combinational program memory,
//               resolves HALT/JUMP locally and issues the rest on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  pmem_addr,
    input  logic [INSTR_W-1:0] pmem_data,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [ADDR_W-1:0]  issue_pc,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   issued_cnt
);

    state_t               state_q,    state_d;
    logic [ADDR_W-1:0]    pc_q,       pc_d;
    logic [INSTR_W-1:0]   ir_q,       ir_d;
    logic [ADDR_W-1:0]    issue_pc_q, issue_pc_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;

    logic [OPCODE_W-1:0]  fetch_op;
    logic [ADDR_W-1:0]    pc_inc;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 xfer;

    assign fetch_op = pmem_data[INSTR_W-1 -: OPCODE_W];
    // Natural modulo-2**ADDR_W wrap of the PC is intended.
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign xfer     = (state_q == ISSUE) && issue_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        issue_pc_d = issue_pc_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                ir_d       = pmem_data;
                issue_pc_d = pc_q;
                if (fetch_op == OP_HALT) begin
                    state_d = HALTED;
                end else if (fetch_op == OP_JUMP) begin
                    pc_d = pmem_data[ADDR_W-1:0];
                end else begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                // IR and issue_pc are held until execute takes the word.
                if (xfer) begin
                    pc_d    = pc_inc;
                    cnt_d   = cnt_inc;
                    state_d = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            issue_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            issue_pc_q <= issue_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pmem_addr   = pc_q;
    assign issue_instr = ir_q;
    assign issue_pc    = issue_pc_q;
    assign issued_cnt  = cnt_q;
    assign issue_valid = (state_q == ISSUE);
    assign busy        = (state_q == FETCH) || (state_q == ISSUE);
    assign halted      = (state_q == HALTED);

endmodule

`default_nettype wire
